// File: rtl/ensemble_vote_combiner.sv
// Three-lane AXI-Stream result combiner: aligns one beat per lane,
// majority-votes the class labels and emits one combined beat per triple.
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           result_count,
  output logic [31:0]           split_count
);

  localparam int CW = CLASS_WIDTH;

  logic [2:0]            held_q, held_d;
  logic [2:0]            last_q, last_d;
  logic [CW-1:0]         label_q [3];
  logic [CW-1:0]         label_d [3];
  logic [CW-1:0]         in_label [3];
  logic [2:0]            in_last;
  logic [2:0]            s_valid;
  logic [2:0]            s_ready;
  logic [2:0]            accept;
  logic                  fire;
  logic                  out_hs;
  logic [CW-1:0]         winner;
  logic [1:0]            votes;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [31:0]           result_cnt_q, result_cnt_d;
  logic [31:0]           split_cnt_q, split_cnt_d;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1,
                           s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:CW],
                           s_axis_tdata_1[DATA_WIDTH-1:CW],
                           s_axis_tdata_2[DATA_WIDTH-1:CW]};

  assign in_label[0] = s_axis_tdata_0[CW-1:0];
  assign in_label[1] = s_axis_tdata_1[CW-1:0];
  assign in_label[2] = s_axis_tdata_2[CW-1:0];
  assign in_last  = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign s_valid  = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

  assign fire    = (&held_q) && (!tvalid_q || m_axis_tready);
  assign out_hs  = tvalid_q && m_axis_tready;
  // Ready is forced low while reset is asserted.
  assign s_ready = {3{rst_n}} & (~held_q | {3{fire}});
  assign accept  = s_valid & s_ready;

  assign s_axis_tready_0 = s_ready[0];
  assign s_axis_tready_1 = s_ready[1];
  assign s_axis_tready_2 = s_ready[2];

  always_comb begin
    held_d  = held_q;
    last_d  = last_q;
    label_d = label_q;
    if (fire) held_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (accept[i]) begin
        held_d[i]  = 1'b1;
        last_d[i]  = in_last[i];
        label_d[i] = in_label[i];
      end
    end
  end

  always_comb begin
    winner = label_q[0];
    votes  = 2'd1;
    if (label_q[0] == label_q[1] && label_q[0] == label_q[2]) begin
      votes = 2'd3;
    end else if (label_q[0] == label_q[1] ||
                 label_q[0] == label_q[2]) begin
      votes = 2'd2;
    end else if (label_q[1] == label_q[2]) begin
      winner = label_q[1];
      votes  = 2'd2;
    end
  end

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (fire) begin
      tdata_d          = '0;
      tdata_d[CW-1:0]  = winner;
      tdata_d[17:16]   = votes;
      tdata_d[24]      = !((&last_q) || !(|last_q));
      tkeep_d          = '1;
      tvalid_d         = 1'b1;
      tlast_d          = |last_q;
    end else if (out_hs) begin
      tdata_d  = '0;
      tkeep_d  = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    result_cnt_d = result_cnt_q + 32'(out_hs);
    split_cnt_d  = split_cnt_q +
                   32'(out_hs && tdata_q[17:16] == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q       <= '0;
      last_q       <= '0;
      for (int i = 0; i < 3; i++) label_q[i] <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      result_cnt_q <= '0;
      split_cnt_q  <= '0;
    end else begin
      held_q       <= held_d;
      last_q       <= last_d;
      for (int i = 0; i < 3; i++) label_q[i] <= label_d[i];
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      result_cnt_q <= result_cnt_d;
      split_cnt_q  <= split_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign result_count  = result_cnt_q;
  assign split_count   = split_cnt_q;

endmodule
